// File: rtl/lsu_gen2_pkg.sv
// Shared types and defaults for the MMIO load/store unit.
package lsu_gen2_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    MEM_WAIT,
    RESP
  } state_e;

  typedef enum logic [1:0] {
    R_DMEM,
    R_OUT,
    R_IN,
    R_NONE
  } region_e;

  localparam logic [31:0] DMEM_BASE_DEF = 32'h0000_2000;
  localparam int          DMEM_BYTES_DEF = 8192;
  localparam logic [31:0] OUT_BASE_DEF  = 32'h0000_7000;
  localparam logic [31:0] IN_BASE_DEF   = 32'h0000_7800;

  // Size code 2'b11 has no legal alignment, so it is always rejected.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == 2'b11) ||
           ((size == SZ_H) && off[0]) ||
           ((size == SZ_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store replication + byte mask, or load extraction + extension.
module lsu_lane_align
  import lsu_gen2_pkg::*;
(
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_data,
  output logic [31:0] o_data,
  output logic [3:0]  o_bmask
);

  logic [15:0] shifted;

  always_comb begin
    shifted = 16'(i_data >> {i_off, 3'b000});
    o_data  = i_data;
    o_bmask = 4'hF;
    if (i_we) begin
      case (i_size)
        SZ_B: begin
          o_data  = {4{i_data[7:0]}};
          o_bmask = 4'b0001 << i_off;
        end
        SZ_H: begin
          o_data  = {2{i_data[15:0]}};
          o_bmask = i_off[1] ? 4'b1100 : 4'b0011;
        end
        default: ;
      endcase
    end else begin
      // Word loads pass through untouched; i_unsigned only matters below a word.
      case (i_size)
        SZ_B:    o_data = {{24{~i_unsigned & shifted[7]}}, shifted[7:0]};
        SZ_H:    o_data = {{16{~i_unsigned & shifted[15]}}, shifted[15:0]};
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/lsu_mmio_gen2.sv
// Load/store unit decoding data memory, output-register bank and synchronised input bank.
module lsu_mmio_gen2
  import lsu_gen2_pkg::*;
#(
  parameter int          NUM_OUT    = 16,
  parameter int          NUM_IN     = 8,
  parameter logic [31:0] DMEM_BASE  = DMEM_BASE_DEF,
  parameter int          DMEM_BYTES = DMEM_BYTES_DEF,
  parameter logic [31:0] OUT_BASE   = OUT_BASE_DEF,
  parameter logic [31:0] IN_BASE    = IN_BASE_DEF,
  parameter int          TIMEOUT    = 255
)(
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_req,
  input  logic                            i_we,
  input  logic [1:0]                      i_size,
  input  logic                            i_unsigned,
  input  logic [31:0]                     i_addr,
  input  logic [31:0]                     i_wdata,
  output logic                            o_ready,
  output logic                            o_done,
  output logic [31:0]                     o_rdata,
  output logic                            o_err,
  output logic                            o_mem_req,
  output logic                            o_mem_we,
  output logic [$clog2(DMEM_BYTES)-3:0]   o_mem_addr,
  output logic [31:0]                     o_mem_wdata,
  output logic [3:0]                      o_mem_bmask,
  input  logic                            i_mem_ack,
  input  logic [31:0]                     i_mem_rdata,
  input  logic [NUM_IN*32-1:0]            i_io_in,
  output logic [NUM_OUT*32-1:0]           o_io_out
);

  localparam int          MAW       = $clog2(DMEM_BYTES) - 2;
  localparam int          OIW       = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int          IIW       = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int          CW        = $clog2(TIMEOUT + 1);
  localparam logic [31:0] DMEM_MASK = ~(32'(DMEM_BYTES) - 32'd1);
  localparam logic [31:0] OUT_SPAN  = 32'(NUM_OUT * 4);
  localparam logic [31:0] IN_SPAN   = 32'(NUM_IN * 4);

  state_e          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  region_e         region;
  logic [31:0]     out_off, in_off;
  logic [OIW-1:0]  out_idx;
  logic [IIW-1:0]  in_idx;
  logic            accept, misal;

  logic [31:0]     out_reg  [NUM_OUT];
  logic [31:0]     sync_reg [NUM_IN];
  logic [31:0]     in_reg   [NUM_IN];

  logic            mem_req_reg, mem_we_reg;
  logic [MAW-1:0]  mem_addr_reg;
  logic [31:0]     mem_wdata_reg;
  logic [3:0]      mem_bmask_reg;
  logic [1:0]      ld_size_reg, ld_off_reg;
  logic            ld_uns_reg;
  logic            done_reg, err_reg;
  logic [31:0]     rdata_reg;

  logic [31:0]     st_data, ld_data, ld_src, st_mask32;
  logic [3:0]      st_bmask, ld_bmask;
  logic [1:0]      ld_size, ld_off;
  logic            ld_uns;
  logic            fin, fin_err, issue, out_wr, mem_drop;
  logic [31:0]     fin_data;

  assign accept  = i_req && (state_reg == IDLE);
  assign misal   = is_misaligned(i_size, i_addr[1:0]);
  assign out_idx = out_off[OIW+1:2];
  assign in_idx  = in_off[IIW+1:2];

  // Out-of-window offsets wrap to huge values, so one unsigned compare bounds each bank.
  always_comb begin
    out_off = i_addr - OUT_BASE;
    in_off  = i_addr - IN_BASE;
    if ((i_addr & DMEM_MASK) == DMEM_BASE) region = R_DMEM;
    else if (out_off < OUT_SPAN)           region = R_OUT;
    else if (in_off < IN_SPAN)             region = R_IN;
    else                                   region = R_NONE;
  end

  // The load aligner sees the live request in IDLE and the captured request while waiting on memory.
  assign ld_size = (state_reg == MEM_WAIT) ? ld_size_reg : i_size;
  assign ld_off  = (state_reg == MEM_WAIT) ? ld_off_reg  : i_addr[1:0];
  assign ld_uns  = (state_reg == MEM_WAIT) ? ld_uns_reg  : i_unsigned;
  assign ld_src  = (state_reg == MEM_WAIT) ? i_mem_rdata :
                   (region == R_IN)        ? in_reg[in_idx] : out_reg[out_idx];

  lsu_lane_align u_store (
    .i_we       (1'b1),
    .i_size     (i_size),
    .i_unsigned (i_unsigned),
    .i_off      (i_addr[1:0]),
    .i_data     (i_wdata),
    .o_data     (st_data),
    .o_bmask    (st_bmask)
  );

  lsu_lane_align u_load (
    .i_we       (1'b0),
    .i_size     (ld_size),
    .i_unsigned (ld_uns),
    .i_off      (ld_off),
    .i_data     (ld_src),
    .o_data     (ld_data),
    .o_bmask    (ld_bmask)
  );

  assign st_mask32 = {{8{st_bmask[3]}}, {8{st_bmask[2]}}, {8{st_bmask[1]}}, {8{st_bmask[0]}}};

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    fin        = 1'b0;
    fin_err    = 1'b0;
    fin_data   = '0;
    issue      = 1'b0;
    out_wr     = 1'b0;
    mem_drop   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (misal || (region == R_NONE)) begin
            state_next = RESP;
            fin        = 1'b1;
            fin_err    = 1'b1;
          end else if (region == R_DMEM) begin
            state_next = MEM_WAIT;
            issue      = 1'b1;
            cnt_next   = '0;
          end else begin
            state_next = RESP;
            fin        = 1'b1;
            fin_data   = i_we ? 32'd0 : ld_data;
            out_wr     = i_we && (region == R_OUT);
          end
        end
      end
      MEM_WAIT: begin
        if (i_mem_ack) begin
          state_next = RESP;
          fin        = 1'b1;
          mem_drop   = 1'b1;
          fin_data   = mem_we_reg ? 32'd0 : ld_data;
        end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
          state_next = RESP;
          fin        = 1'b1;
          fin_err    = 1'b1;
          mem_drop   = 1'b1;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_bmask_reg <= '0;
      ld_size_reg   <= '0;
      ld_off_reg    <= '0;
      ld_uns_reg    <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      rdata_reg     <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (issue) begin
        mem_req_reg   <= 1'b1;
        mem_we_reg    <= i_we;
        mem_addr_reg  <= i_addr[MAW+1:2];
        mem_wdata_reg <= st_data;
        mem_bmask_reg <= i_we ? st_bmask : ld_bmask;
        ld_size_reg   <= i_size;
        ld_off_reg    <= i_addr[1:0];
        ld_uns_reg    <= i_unsigned;
      end else if (mem_drop) begin
        mem_req_reg <= 1'b0;
      end
      done_reg <= fin;
      err_reg  <= fin && fin_err;
      if (fin) rdata_reg <= fin_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_OUT; i++) out_reg[i] <= '0;
    end else if (out_wr) begin
      out_reg[out_idx] <= (out_reg[out_idx] & ~st_mask32) | (st_data & st_mask32);
    end
  end

  // Two-flop synchroniser; the second stage is the architecturally visible input register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_IN; i++) begin
        sync_reg[i] <= '0;
        in_reg[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        sync_reg[i] <= i_io_in[i*32 +: 32];
        in_reg[i]   <= sync_reg[i];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUT; gi++) begin : g_out
      assign o_io_out[gi*32 +: 32] = out_reg[gi];
    end
  endgenerate

  assign o_ready     = (state_reg == IDLE);
  assign o_done      = done_reg;
  assign o_err       = err_reg;
  assign o_rdata     = rdata_reg;
  assign o_mem_req   = mem_req_reg;
  assign o_mem_we    = mem_we_reg;
  assign o_mem_addr  = mem_addr_reg;
  assign o_mem_wdata = mem_wdata_reg;
  assign o_mem_bmask = mem_bmask_reg;

endmodule

// File: doc/lsu_mmio_gen2.md
Name: lsu_mmio_gen2

Overview:
Parametrised load/store unit that decodes a byte address into three regions: a data memory behind a req/ack handshake port, an output-peripheral register bank, and an input-peripheral register bank. It adds SB/SH/SW byte-lane stores with byte masks, LB/LBU/LH/LHU/LW extraction with sign or zero extension, misalignment and unmapped-address detection, a memory-wait timeout, and synchronised continuous sampling of the input peripherals. It sits between the core's MEM stage and the memory/IO subsystem, and stalls the core via o_ready.

Parameters:
NUM_OUT, 16, number of 32-bit output peripheral registers (power of 2, 1..64)
NUM_IN, 8, number of 32-bit input peripheral registers (power of 2, 1..64)
DMEM_BASE, 32'h0000_2000, byte base of data memory (aligned to DMEM_BYTES)
DMEM_BYTES, 8192, data memory size in bytes (power of 2)
OUT_BASE, 32'h0000_7000, byte base of output bank
IN_BASE, 32'h0000_7800, byte base of input bank
TIMEOUT, 255, maximum MEM_WAIT cycles before an error response (>=2)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_req  in  1  access request, accepted when i_req && o_ready
i_we  in  1  1 = store, 0 = load
i_size  in  2  00 byte, 01 half, 10 word; 11 is treated as misaligned
i_unsigned  in  1  zero-extend a sub-word load
i_addr  in  32  byte address
i_wdata  in  32  store data, right-aligned
o_ready  out  1  LSU idle, can accept
o_done  out  1  one-cycle completion pulse
o_rdata  out  32  load result, valid with o_done
o_err  out  1  misaligned, unmapped or timeout; valid with o_done
o_mem_req  out  1  memory request, held until ack
o_mem_we  out  1  memory write
o_mem_addr  out  $clog2(DMEM_BYTES)-2  word address
o_mem_wdata  out  32  lane-replicated store data
o_mem_bmask  out  4  byte enables
i_mem_ack  in  1  memory completion
i_mem_rdata  in  32  memory read data, valid with ack
i_io_in  in  NUM_IN*32  asynchronous input words, flattened
o_io_out  out  NUM_OUT*32  output registers, flattened

Behaviour:
- Reset (async, i_rst_n=0): FSM=IDLE, o_ready=1, o_done=0, o_err=0, o_rdata=0, o_mem_req=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_mem_bmask=0, all output and input registers = 0, sync flops = 0. A reset mid-transaction drops o_mem_req immediately and no o_done is produced.
- FSM states: IDLE, MEM_WAIT, RESP. o_ready=1 only in IDLE.
- IDLE with accept:
  - Misaligned (half at addr[0]=1, word at addr[1:0]!=0, or size=11): no side effect. Go to RESP with err=1, rdata=0.
  - Unmapped address: same as misaligned, err=1.
  - Output bank: a store read-modify-writes the selected bytes into out[(addr-OUT_BASE)>>2] at the accept edge. The change is visible on o_io_out the next cycle. A load returns the extracted value. Go to RESP, err=0.
  - Input bank: a load returns the extracted value of the synchronised register. A store is ignored, err=0. Go to RESP.
  - DMEM: at the accept edge, register o_mem_req=1, o_mem_we, o_mem_addr, o_mem_wdata and o_mem_bmask (all 1 for loads). Clear the wait counter. Go to MEM_WAIT.
- MEM_WAIT: the memory outputs are held stable.
  - i_mem_ack=1: deassert o_mem_req, capture the extracted/extended i_mem_rdata (loads), go to RESP with err=0.
  - Otherwise increment the counter. When the counter reaches TIMEOUT without ack: deassert o_mem_req, go to RESP with err=1, rdata=0.
  - An ack arriving in any other state is ignored.
- RESP: o_done=1 for exactly one cycle with o_rdata/o_err, then IDLE. o_rdata holds its value until the next o_done.
- Latency: peripheral, misaligned and unmapped accesses take 2 cycles accept-to-done. A DMEM access takes ack-cycle+1.
- Lane rules:
  - Store byte: wdata[7:0] replicated to all 4 lanes, bmask=1<<addr[1:0].
  - Store half: wdata[15:0] replicated to both halves, bmask=0011 or 1100.
  - Load: select lane by addr[1:0]; sign-extend unless i_unsigned. i_unsigned is ignored for word loads.
- Input sync: every cycle, each i_io_in word passes through 2 flops into the input register (no store trigger). Reads see the value sampled 2 cycles earlier.
- Bank index width is $clog2(NUM_x). Addresses beyond NUM_x*4 bytes from a bank base are unmapped.

Decomposition:
- Package lsu_gen2_pkg:
  - size_e (SZ_B, SZ_H, SZ_W)
  - state_e (IDLE, MEM_WAIT, RESP)
  - region_e (R_DMEM, R_OUT, R_IN, R_NONE)
  - default base constants
- Sub-module lsu_lane_align (combinational): store replication + bmask generation, load lane extraction + extension. It is instantiated once for the store path and once for the load path.

Test Plan:
- SW 0xDEADBEEF to 0x7004, then LW 0x7004 -> o_io_out word1=0xDEADBEEF one cycle after accept; load o_done at cycle 2 with rdata 0xDEADBEEF, err=0.
- SB 0x80 to 0x7001 over 0x11223344, then LB and LBU 0x7001 -> register=0x11228044; LB rdata=0xFFFFFF80; LBU rdata=0x00000080.
- LH 0x2006 with memory ack after 3 cycles and rdata 0x8001_0000 -> o_mem_req high 3 cycles, bmask=1111; o_done 1 cycle after ack with rdata 0xFFFF8001.
- SH 0x1234 to 0x2003 -> no o_mem_req, o_done at cycle 2 with err=1; SW to 0x5000 (unmapped) -> err=1.
- DMEM load with no ack, TIMEOUT=4 -> o_mem_req drops after 4 wait cycles, o_done with err=1, rdata=0; a late ack is ignored.
- Drive i_io_in word2=0xA5 and LW 0x7808 -> rdata 0xA5 once 2 cycles have elapsed; assert i_rst_n=0 in MEM_WAIT -> o_mem_req=0 immediately, o_ready=1, no o_done.
